// File: rtl/cache_axi_refill_pkg.sv
// Shared widths, AXI constants and FSM encoding for the dcache refill responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cache_axi_refill_pkg;

    localparam int LINE_WD     = 256;
    localparam int BEAT_WD     = 32;
    localparam int BEATS       = LINE_WD / BEAT_WD;
    localparam int OFFSET_WD   = 5;
    localparam int BEAT_IDX_WD = $clog2(BEATS);

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [7:0] AXI_LEN_LINE   = 8'(BEATS - 1);
    localparam logic [3:0] AXI_STRB_FULL  = 4'hF;

    localparam logic [BEAT_IDX_WD-1:0] LAST_BEAT = BEAT_IDX_WD'(BEATS - 1);

    // Clears the line-offset bits so bursts always start on a line boundary.
    localparam logic [31:0] LINE_ADDR_MASK = ~((32'd1 << OFFSET_WD) - 32'd1);

    typedef enum logic [7:0] {
        S_IDLE   = 8'b0000_0001,
        S_AW     = 8'b0000_0010,
        S_W      = 8'b0000_0100,
        S_B      = 8'b0000_1000,
        S_AR     = 8'b0001_0000,
        S_R      = 8'b0010_0000,
        S_RELOAD = 8'b0100_0000,
        S_HOLD   = 8'b1000_0000
    } state_t;

endpackage

// File: rtl/cache_axi_refill_line_buf.sv
// Cache line buffer: parallel load / indexed beat read, indexed beat write / parallel read.
// Latency: writes land on the next clk edge; both read paths are combinational from the store.
// Backpressure: none; the owner decides when to load or write.
// Ports: load/load_line parallel fill; wr/idx/wr_beat beat write; rd_beat = beat idx; line = whole store.
module cache_axi_refill_line_buf
    import cache_axi_refill_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [LINE_WD-1:0]     load_line,
    input  logic                   wr,
    input  logic [BEAT_IDX_WD-1:0] idx,
    input  logic [BEAT_WD-1:0]     wr_beat,
    output logic [BEAT_WD-1:0]     rd_beat,
    output logic [LINE_WD-1:0]     line
);

    logic [BEATS-1:0][BEAT_WD-1:0] mem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '0;
        end else if (load) begin
            mem <= load_line;
        end else if (wr) begin
            mem[idx] <= wr_beat;
        end
    end

    assign rd_beat = mem[idx];
    assign line    = mem;

endmodule

// File: rtl/cache_axi_refill.sv
// Dcache miss responder: optional 8-beat victim writeback, then 8-beat line fetch, then reload pulse.
// Latency: clean miss reloads in cycle 11 (IDLE+AR+8R+RELOAD); a dirty victim adds AW+8W+B.
// Backpressure: every AXI ready/valid low simply stalls the current state; no timeout.
// Ports: rd_req/rd_addr, wr_req/wr_addr/cacheline_old from the cache; reload/cacheline_new back;
//        AR/R/AW/W/B AXI master channels (IDs, cache, prot, lock are fixed by the wrapper).
module cache_axi_refill
    import cache_axi_refill_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    input  logic               rd_req,
    input  logic [31:0]        rd_addr,
    input  logic               wr_req,
    input  logic [31:0]        wr_addr,
    input  logic [LINE_WD-1:0] cacheline_old,
    output logic               reload,
    output logic [LINE_WD-1:0] cacheline_new,
    output logic [31:0]        araddr,
    output logic [7:0]         arlen,
    output logic [2:0]         arsize,
    output logic [1:0]         arburst,
    output logic               arvalid,
    input  logic               arready,
    input  logic [31:0]        rdata,
    input  logic               rvalid,
    output logic               rready,
    output logic [31:0]        awaddr,
    output logic [7:0]         awlen,
    output logic [2:0]         awsize,
    output logic [1:0]         awburst,
    output logic               awvalid,
    input  logic               awready,
    output logic [31:0]        wdata,
    output logic [3:0]         wstrb,
    output logic               wlast,
    output logic               wvalid,
    input  logic               wready,
    input  logic               bvalid,
    output logic               bready
);

    state_t                 state;
    logic [BEAT_IDX_WD-1:0] beat;
    logic [31:0]            rd_addr_q;
    logic [31:0]            wr_addr_q;

    logic                   load_victim;
    logic                   refill_wr;
    logic [LINE_WD-1:0]     wb_line;
    logic [BEAT_WD-1:0]     rf_beat;
    logic                   unused_buf_outs;

    // Single FSM; beat is shared by W and R and wraps to 0 after the 8th handshake,
    // so it is already cleared when the next burst starts.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            beat      <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            arvalid   <= 1'b0;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            rready    <= 1'b0;
            reload    <= 1'b0;
        end else begin
            reload <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rd_req) begin
                        rd_addr_q <= rd_addr & LINE_ADDR_MASK;
                        beat      <= '0;
                        if (wr_req) begin
                            wr_addr_q <= wr_addr & LINE_ADDR_MASK;
                            awvalid   <= 1'b1;
                            state     <= S_AW;
                        end else begin
                            arvalid <= 1'b1;
                            state   <= S_AR;
                        end
                    end
                end
                S_AW: begin
                    if (awready) begin
                        awvalid <= 1'b0;
                        wvalid  <= 1'b1;
                        state   <= S_W;
                    end
                end
                S_W: begin
                    if (wready) begin
                        beat <= beat + 1'b1;
                        if (beat == LAST_BEAT) begin
                            wvalid <= 1'b0;
                            bready <= 1'b1;
                            state  <= S_B;
                        end
                    end
                end
                S_B: begin
                    if (bvalid) begin
                        bready  <= 1'b0;
                        arvalid <= 1'b1;
                        state   <= S_AR;
                    end
                end
                S_AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= S_R;
                    end
                end
                S_R: begin
                    if (rvalid) begin
                        beat <= beat + 1'b1;
                        if (beat == LAST_BEAT) begin
                            rready <= 1'b0;
                            reload <= 1'b1;
                            state  <= S_RELOAD;
                        end
                    end
                end
                S_RELOAD: state <= S_HOLD;
                // The cache updates its tags here and rd_req is not meaningful yet.
                S_HOLD:   state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    assign load_victim = (state == S_IDLE) && rd_req && wr_req;
    assign refill_wr   = (state == S_R) && rvalid;

    cache_axi_refill_line_buf u_wb_buf (
        .clk       (clk),
        .rst_n     (resetn),
        .load      (load_victim),
        .load_line (cacheline_old),
        .wr        (1'b0),
        .idx       (beat),
        .wr_beat   ('0),
        .rd_beat   (wdata),
        .line      (wb_line)
    );

    cache_axi_refill_line_buf u_rf_buf (
        .clk       (clk),
        .rst_n     (resetn),
        .load      (1'b0),
        .load_line ('0),
        .wr        (refill_wr),
        .idx       (beat),
        .wr_beat   (rdata),
        .rd_beat   (rf_beat),
        .line      (cacheline_new)
    );

    assign unused_buf_outs = ^{wb_line, rf_beat};

    assign araddr  = rd_addr_q;
    assign arlen   = AXI_LEN_LINE;
    assign arsize  = AXI_SIZE_4B;
    assign arburst = AXI_BURST_INCR;
    assign awaddr  = wr_addr_q;
    assign awlen   = AXI_LEN_LINE;
    assign awsize  = AXI_SIZE_4B;
    assign awburst = AXI_BURST_INCR;
    assign wstrb   = AXI_STRB_FULL;
    assign wlast   = wvalid && (beat == LAST_BEAT);

endmodule

// File: tb/tb_cache_axi_refill.sv
// Bench for cache_axi_refill: AXI slave model plus scoreboard queues for AR, AW, W and reload.
// Latency: n/a.
// Backpressure: slave can stall AW/AR/W readies and gap rvalid.
module tb_cache_axi_refill;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         rd_req = 1'b0;
    logic [31:0]  rd_addr = '0;
    logic         wr_req = 1'b0;
    logic [31:0]  wr_addr = '0;
    logic [255:0] cacheline_old = '0;
    logic         reload;
    logic [255:0] cacheline_new;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid;
    logic         arready = 1'b0;
    logic [31:0]  rdata = '0;
    logic         rvalid = 1'b0;
    logic         rready;
    logic [31:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic         awvalid;
    logic         awready = 1'b0;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready = 1'b0;
    logic         bvalid = 1'b0;
    logic         bready;

    cache_axi_refill dut (
        .clk(clk), .resetn(resetn),
        .rd_req(rd_req), .rd_addr(rd_addr), .wr_req(wr_req), .wr_addr(wr_addr),
        .cacheline_old(cacheline_old), .reload(reload), .cacheline_new(cacheline_new),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int chk_cnt = 0;
    int pass_cnt = 0;

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // Scoreboard queues
    logic [31:0]  exp_ar[$];
    logic [31:0]  exp_aw[$];
    logic [32:0]  exp_w[$];
    logic [255:0] exp_line[$];

    // Slave model state
    bit          bp_en = 0;
    logic [31:0] rd_seed = '0;
    int          r_left = 0;
    int          r_beat = 0;
    bit          b_pend = 0;
    bit          wb_pending = 0;
    bit          b_seen = 0;
    int          aw_wait = 0, ar_wait = 0, w_wait = 0;
    int          ar_cnt = 0, aw_cnt = 0, w_cnt = 0, reload_cnt = 0;
    bit          w_hold_vld = 0;
    logic [31:0] w_hold_dat = '0;

    // Slave drivers: update just after each rising edge.
    initial begin
        forever begin
            @(posedge clk); #1;
            aw_wait = awvalid ? aw_wait + 1 : 0;
            ar_wait = arvalid ? ar_wait + 1 : 0;
            w_wait  = wvalid  ? w_wait + 1  : 0;
            awready = !bp_en || (aw_wait > 5);
            arready = !bp_en || (ar_wait > 5);
            wready  = !bp_en || ((w_wait > 5) && ((w_wait % 3) != 0));
            bvalid  = b_pend;
            if (r_left > 0) begin
                rvalid = bp_en ? ~rvalid : 1'b1;
                rdata  = rd_seed + 32'((r_beat + 1) * 32'h11);
            end else begin
                rvalid = 1'b0;
            end
        end
    end

    // Monitor: sample at the falling edge, i.e. the values the next rising edge will use.
    initial begin
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (arvalid && arready) begin
                    ar_cnt++;
                    chk("ar_ctl", {arlen, arsize, arburst}, {8'd7, 3'b010, 2'b01});
                    if (exp_ar.size() == 0) chk("ar_unexpected", 1, 0);
                    else chk("araddr", araddr, exp_ar.pop_front());
                    if (wb_pending) chk("b_before_ar", b_seen, 1);
                    wb_pending = 0;
                    r_left = 8;
                    r_beat = 0;
                end
                if (awvalid && awready) begin
                    aw_cnt++;
                    chk("aw_ctl", {awlen, awsize, awburst}, {8'd7, 3'b010, 2'b01});
                    if (exp_aw.size() == 0) chk("aw_unexpected", 1, 0);
                    else chk("awaddr", awaddr, exp_aw.pop_front());
                    wb_pending = 1;
                    b_seen = 0;
                end
                if (wvalid) begin
                    if (w_hold_vld) chk("w_stable", wdata, w_hold_dat);
                    w_hold_vld = !wready;
                    w_hold_dat = wdata;
                end else begin
                    w_hold_vld = 0;
                end
                if (wvalid && wready) begin
                    w_cnt++;
                    if (exp_w.size() == 0) chk("w_unexpected", 1, 0);
                    else chk("w_beat", {wlast, wdata}, exp_w.pop_front());
                    if (wlast) b_pend = 1;
                end
                if (bvalid && bready) begin
                    b_pend = 0;
                    b_seen = 1;
                end
                if (rvalid && rready) begin
                    r_beat++;
                    r_left--;
                end
                if (reload) begin
                    reload_cnt++;
                    if (exp_line.size() == 0) chk("reload_unexpected", 1, 0);
                    else chk("cacheline_new", cacheline_new, exp_line.pop_front());
                end
            end
        end
    end

    task automatic do_miss(input logic [31:0] addr, input logic dirty, input logic [31:0] waddr,
                           input logic [31:0] old_base, input logic [31:0] seed,
                           input int hold_after, input logic scramble, output int lat);
        logic [255:0] old_line;
        logic [255:0] new_line;
        int aw0;
        bit done;
        bit scr;
        for (int k = 0; k < 8; k++) begin
            old_line[k*32 +: 32] = old_base + 32'(k);
            new_line[k*32 +: 32] = seed + 32'((k + 1) * 32'h11);
        end
        exp_ar.push_back(addr);
        if (dirty) begin
            exp_aw.push_back(waddr);
            for (int k = 0; k < 8; k++) exp_w.push_back({k == 7, old_line[k*32 +: 32]});
        end
        exp_line.push_back(new_line);
        rd_seed       = seed;
        rd_req        = 1'b1;
        rd_addr       = addr;
        wr_req        = dirty;
        wr_addr       = waddr;
        cacheline_old = old_line;
        aw0  = aw_cnt;
        lat  = 0;
        done = 0;
        scr  = 0;
        for (int c = 0; c < 500 && !done; c++) begin
            @(posedge clk); #1;
            lat++;
            if (reload) done = 1;
            if (scramble && !scr && aw_cnt != aw0) begin
                cacheline_old = ~cacheline_old;
                rd_addr       = addr ^ 32'h00F0_0000;
                wr_addr       = waddr ^ 32'h00F0_0000;
                scr = 1;
            end
        end
        if (!done) chk("reload_timeout", 0, 1);
        repeat (hold_after) begin
            @(posedge clk); #1;
        end
        rd_req = 1'b0;
        wr_req = 1'b0;
    endtask

    initial begin
        int lat;
        int ar0, aw0, w0;
        bit hit;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", {arvalid, awvalid, wvalid, rready, bready, reload}, 6'b0);
        chk("rst_line", cacheline_new, 256'h0);
        chk("const_wstrb", wstrb, 4'hF);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Clean miss: 1 IDLE + 1 AR + 8 R edges before reload is visible.
        ar0 = ar_cnt; aw0 = aw_cnt;
        do_miss(32'h0000_1240, 1'b0, 32'h0, 32'h0, 32'h0, 0, 1'b0, lat);
        chk("clean_lat", lat, 10);
        chk("clean_ar_cnt", ar_cnt - ar0, 1);
        chk("clean_no_aw", aw_cnt - aw0, 0);
        repeat (2) @(posedge clk); #1;

        // Dirty miss: adds AW + 8 W + B.
        ar0 = ar_cnt; aw0 = aw_cnt; w0 = w_cnt;
        do_miss(32'h0000_2480, 1'b1, 32'h0000_8240, 32'hA0, 32'h1000, 0, 1'b0, lat);
        chk("dirty_lat", lat, 20);
        chk("dirty_aw_cnt", aw_cnt - aw0, 1);
        chk("dirty_w_cnt", w_cnt - w0, 8);
        repeat (2) @(posedge clk); #1;

        // Backpressure on AW/W/AR, gapped R.
        bp_en = 1;
        w0 = w_cnt;
        do_miss(32'h0000_3300, 1'b1, 32'h0000_9300, 32'hB0, 32'h2000, 0, 1'b0, lat);
        chk("bp_w_cnt", w_cnt - w0, 8);
        bp_en = 0;
        repeat (2) @(posedge clk); #1;

        // Cache inputs move after AW: latched line/addresses must be used.
        do_miss(32'h0000_7700, 1'b1, 32'h0000_A700, 32'hC0, 32'h3000, 0, 1'b1, lat);
        repeat (2) @(posedge clk); #1;

        // Held request, then an immediate second miss.
        ar0 = ar_cnt;
        do_miss(32'h0000_4440, 1'b0, 32'h0, 32'h0, 32'h4000, 2, 1'b0, lat);
        chk("held_one_ar", ar_cnt - ar0, 1);
        do_miss(32'h0000_5540, 1'b0, 32'h0, 32'h0, 32'h5000, 0, 1'b0, lat);
        chk("second_ar", ar_cnt - ar0, 2);
        repeat (2) @(posedge clk); #1;

        // Reset during W beat 3.
        exp_aw.push_back(32'h0000_B100);
        for (int k = 0; k < 8; k++) exp_w.push_back({k == 7, 32'hD0 + 32'(k)});
        for (int k = 0; k < 8; k++) cacheline_old[k*32 +: 32] = 32'hD0 + 32'(k);
        rd_req = 1'b1; rd_addr = 32'h0000_6100; wr_req = 1'b1; wr_addr = 32'h0000_B100;
        w0 = w_cnt;
        hit = 0;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(posedge clk); #1;
            if (w_cnt - w0 >= 3) hit = 1;
        end
        chk("reach_w3", hit, 1);
        #2 resetn = 1'b0;
        #1;
        chk("midrst_outs", {arvalid, awvalid, wvalid, rready, bready, reload}, 6'b0);
        chk("midrst_line", cacheline_new, 256'h0);
        exp_ar.delete(); exp_aw.delete(); exp_w.delete(); exp_line.delete();
        r_left = 0; b_pend = 0; wb_pending = 0;
        rd_req = 1'b0; wr_req = 1'b0;
        repeat (2) @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        ar0 = ar_cnt;
        do_miss(32'h0000_6600, 1'b0, 32'h0, 32'h0, 32'h6000, 0, 1'b0, lat);
        chk("post_rst_lat", lat, 10);
        chk("post_rst_ar", ar_cnt - ar0, 1);
        repeat (3) @(posedge clk); #1;

        chk("sb_empty", exp_ar.size() + exp_aw.size() + exp_w.size() + exp_line.size(), 0);
        chk("reload_total", reload_cnt, 7);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
